// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit and its neighbours (EXU, WBU).
// Holds the LSU FSM state type, the load-mask encodings EXU produces, the
// LSB-aligned store byte masks, and the write-back source (wdOp) encodings.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_SEND = 2'd3
  } lsu_state_e;

  // Load masks as delivered by EXU
  localparam logic [31:0] MASK_B = 32'h0000_00FF;
  localparam logic [31:0] MASK_H = 32'h0000_FFFF;
  localparam logic [31:0] MASK_W = 32'hFFFF_FFFF;

  // Store byte masks, LSB-aligned
  localparam logic [3:0] WMASK_B = 4'b0001;
  localparam logic [3:0] WMASK_H = 4'b0011;
  localparam logic [3:0] WMASK_W = 4'b1111;

  // Write-back source select, shared with EXU and WBU
  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;
  localparam logic [1:0] WD_IMM = 2'd3;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for a 32-bit data bus.
//   addr_lo    : addr[1:0] of the access
//   wdata/wmask: LSB-aligned store data and byte mask
//   rmask      : load mask (MASK_B / MASK_H / MASK_W)
//   rsigned    : sign-extend the load result
//   is_store   : selects which mask drives the misalign check
//   rdata      : word returned by memory
//   wdata_sh   : store data shifted into its byte lanes
//   wstrb_sh   : byte strobes shifted into lanes, truncated to 4 bits
//   load_data  : extracted, masked and optionally sign-extended load value
//   misaligned : halfword on odd address or word on non-word address
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic [31:0] rmask,
  input  logic        rsigned,
  input  logic        is_store,
  input  logic [31:0] rdata,
  output logic [31:0] wdata_sh,
  output logic [3:0]  wstrb_sh,
  output logic [31:0] load_data,
  output logic        misaligned
);

  function automatic logic signed [31:0] sext(input logic [31:0] v, input logic [31:0] m);
    logic signed [31:0] r;
    r = v;
    if (m == MASK_B) r = {{24{v[7]}}, v[7:0]};
    else if (m == MASK_H) r = {{16{v[15]}}, v[15:0]};
    return r;
  endfunction

  logic [4:0]  sh;
  logic [31:0] raw;

  always_comb begin
    sh       = {addr_lo, 3'b000};
    wdata_sh = wdata << sh;
    wstrb_sh = wmask << addr_lo;
    raw      = (rdata >> sh) & rmask;
    load_data = rsigned ? sext(raw, rmask) : raw;
    if (is_store)
      misaligned = ((wmask == WMASK_H) && addr_lo[0]) ||
                   ((wmask == WMASK_W) && (addr_lo != 2'b00));
    else
      misaligned = ((rmask == MASK_H) && addr_lo[0]) ||
                   ((rmask == MASK_W) && (addr_lo != 2'b00));
  end

endmodule

// File: rtl/lsu.sv
// Load/store stage between EXU and WBU.
// Accepts one instruction per handshake, issues at most one data-memory
// request, aligns/extends load data and presents the result plus the
// latched write-back controls to WBU.
//   clk, rst (async, active-low)
//   EXU side : lsu_receive_valid / lsu_send_ready, addr/wdata/masks/controls
//   bus side : mem_req_valid/ready, mem_addr/wen/wdata/wstrb,
//              mem_resp_valid, mem_rdata, mem_resp_err
//   WBU side : lsu_send_valid / lsu_receive_ready, mem_result, alu_result,
//              reg_write_en, rd, pc, wdOp, lsu_err
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            lsu_receive_valid,
  output logic            lsu_send_ready,
  input  logic [XLEN-1:0] addr_input,
  input  logic [XLEN-1:0] wdata_input,
  input  logic            ren_input,
  input  logic            wen_input,
  input  logic [7:0]      wmask_input,
  input  logic [XLEN-1:0] rmask_input,
  input  logic            memory_read_signed_input,
  input  logic            reg_write_en_input,
  input  logic [4:0]      rd_input,
  input  logic [XLEN-1:0] pc_input,
  input  logic [1:0]      wdOp_input,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_resp_err,
  output logic            lsu_send_valid,
  input  logic            lsu_receive_ready,
  output logic [XLEN-1:0] mem_result,
  output logic [XLEN-1:0] alu_result,
  output logic            reg_write_en,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] pc,
  output logic [1:0]      wdOp,
  output logic            lsu_err
);

  // WAIT cycles counted from 0; the last permitted cycle is TIMEOUT-1
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  lsu_state_e  state;
  logic [15:0] cnt;

  // Access attributes latched at accept, needed again when the response lands
  logic [1:0]  addr_lo_p0;
  logic [31:0] rmask_p0;
  logic        rsigned_p0;
  logic        is_load_p0;

  logic        is_store_in;
  logic        is_load_in;
  logic        is_mem_in;
  logic [1:0]  addr_sel;
  logic [31:0] rmask_sel;
  logic        rsigned_sel;
  logic [31:0] wdata_sh;
  logic [3:0]  wstrb_sh;
  logic [31:0] load_data;
  logic        misaligned;
  logic        unused_wmask_hi;

  assign unused_wmask_hi = ^wmask_input[7:4];

  // A request with both ren and wen set is handled as a store.
  // The aligner looks at the live inputs while IDLE (store lanes, misalign
  // check) and at the latched attributes afterwards (load extraction).
  always_comb begin
    is_store_in = wen_input;
    is_load_in  = ren_input & ~wen_input;
    is_mem_in   = ren_input | wen_input;
    if (state == S_IDLE) begin
      addr_sel    = addr_input[1:0];
      rmask_sel   = rmask_input;
      rsigned_sel = memory_read_signed_input;
    end else begin
      addr_sel    = addr_lo_p0;
      rmask_sel   = rmask_p0;
      rsigned_sel = rsigned_p0;
    end
  end

  lsu_align u_align (
    .addr_lo    (addr_sel),
    .wdata      (wdata_input),
    .wmask      (wmask_input[3:0]),
    .rmask      (rmask_sel),
    .rsigned    (rsigned_sel),
    .is_store   (is_store_in),
    .rdata      (mem_rdata),
    .wdata_sh   (wdata_sh),
    .wstrb_sh   (wstrb_sh),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      addr_lo_p0     <= '0;
      rmask_p0       <= '0;
      rsigned_p0     <= 1'b0;
      is_load_p0     <= 1'b0;
      lsu_send_ready <= 1'b1;
      lsu_send_valid <= 1'b0;
      mem_req_valid  <= 1'b0;
      mem_addr       <= '0;
      mem_wen        <= 1'b0;
      mem_wdata      <= '0;
      mem_wstrb      <= '0;
      mem_result     <= '0;
      alu_result     <= '0;
      reg_write_en   <= 1'b0;
      rd             <= '0;
      pc             <= '0;
      wdOp           <= '0;
      lsu_err        <= 1'b0;
    end else begin
      unique case (state)
        // Accept stage: latch the instruction and decide the path
        S_IDLE: begin
          if (lsu_receive_valid) begin
            lsu_send_ready <= 1'b0;
            alu_result     <= addr_input;
            reg_write_en   <= reg_write_en_input;
            rd             <= rd_input;
            pc             <= pc_input;
            wdOp           <= wdOp_input;
            addr_lo_p0     <= addr_input[1:0];
            rmask_p0       <= rmask_input;
            rsigned_p0     <= memory_read_signed_input;
            is_load_p0     <= is_load_in;
            mem_addr       <= {addr_input[XLEN-1:2], 2'b00};
            mem_wen        <= is_store_in;
            mem_wdata      <= is_store_in ? wdata_sh : '0;
            mem_wstrb      <= is_store_in ? wstrb_sh : 4'b0000;
            mem_result     <= '0;
            lsu_err        <= 1'b0;
            if (!is_mem_in) begin
              lsu_send_valid <= 1'b1;
              state          <= S_SEND;
            end else if (misaligned) begin
              lsu_err        <= 1'b1;
              lsu_send_valid <= 1'b1;
              state          <= S_SEND;
            end else begin
              mem_req_valid  <= 1'b1;
              state          <= S_REQ;
            end
          end
        end
        // Request stage: hold the request until the bus takes it
        S_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            cnt           <= '0;
            state         <= S_WAIT;
          end
        end
        // Response stage: a response arriving on the last cycle still wins
        S_WAIT: begin
          if (mem_resp_valid) begin
            mem_result     <= is_load_p0 ? load_data : '0;
            lsu_err        <= mem_resp_err;
            lsu_send_valid <= 1'b1;
            state          <= S_SEND;
          end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
            mem_result     <= '0;
            lsu_err        <= 1'b1;
            lsu_send_valid <= 1'b1;
            state          <= S_SEND;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        // Hand-off stage: hold the result until WBU takes it
        S_SEND: begin
          if (lsu_receive_ready) begin
            lsu_send_valid <= 1'b0;
            lsu_send_ready <= 1'b1;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;
  import lsu_pkg::*;

  logic        clk;
  logic        rst;
  logic        lsu_receive_valid;
  logic        lsu_send_ready;
  logic [31:0] addr_input;
  logic [31:0] wdata_input;
  logic        ren_input;
  logic        wen_input;
  logic [7:0]  wmask_input;
  logic [31:0] rmask_input;
  logic        memory_read_signed_input;
  logic        reg_write_en_input;
  logic [4:0]  rd_input;
  logic [31:0] pc_input;
  logic [1:0]  wdOp_input;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        mem_resp_err;
  logic        lsu_send_valid;
  logic        lsu_receive_ready;
  logic [31:0] mem_result;
  logic [31:0] alu_result;
  logic        reg_write_en;
  logic [4:0]  rd;
  logic [31:0] pc;
  logic [1:0]  wdOp;
  logic        lsu_err;

  int n_cmp = 0;
  int n_err = 0;

  lsu #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .lsu_receive_valid(lsu_receive_valid), .lsu_send_ready(lsu_send_ready),
    .addr_input(addr_input), .wdata_input(wdata_input),
    .ren_input(ren_input), .wen_input(wen_input),
    .wmask_input(wmask_input), .rmask_input(rmask_input),
    .memory_read_signed_input(memory_read_signed_input),
    .reg_write_en_input(reg_write_en_input), .rd_input(rd_input),
    .pc_input(pc_input), .wdOp_input(wdOp_input),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err),
    .lsu_send_valid(lsu_send_valid), .lsu_receive_ready(lsu_receive_ready),
    .mem_result(mem_result), .alu_result(alu_result),
    .reg_write_en(reg_write_en), .rd(rd), .pc(pc), .wdOp(wdOp),
    .lsu_err(lsu_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    if (obs !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, req);
    end
  endtask

  // ---- reference model: byte-oriented view of the access ----
  function automatic int acc_bytes(input logic wen, input logic [7:0] wmask, input logic [31:0] rmask);
    if (wen) return (wmask[3:0] == 4'b1111) ? 4 : (wmask[3:0] == 4'b0011) ? 2 : 1;
    return (rmask == 32'hFFFF_FFFF) ? 4 : (rmask == 32'h0000_FFFF) ? 2 : 1;
  endfunction

  function automatic logic m_mis(input logic [31:0] a, input logic wen, input logic [7:0] wmask,
                                 input logic [31:0] rmask);
    int off;
    off = int'(a[1:0]);
    return (off % acc_bytes(wen, wmask, rmask)) != 0;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    int off;
    off = int'(a[1:0]);
    r = '0;
    for (int i = 0; i < 4; i++)
      if (off + i < 4) r[8*(off+i) +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [31:0] a, input logic [7:0] m);
    logic [3:0] r;
    int off;
    off = int'(a[1:0]);
    r = '0;
    for (int i = 0; i < 4; i++)
      if (m[i] && (off + i < 4)) r[off+i] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [31:0] rdata,
                                         input logic [31:0] rmask, input logic sgn);
    logic [31:0] v;
    int off, n;
    off = int'(a[1:0]);
    n = acc_bytes(1'b0, 8'h0, rmask);
    v = '0;
    for (int i = 0; i < n; i++)
      if (off + i < 4) v[8*i +: 8] = rdata[8*(off+i) +: 8];
    if (sgn && (n < 4) && v[8*n-1]) v = v - (32'd1 << (8*n));
    return v;
  endfunction

  logic [1:0] wd_tab [4];

  // One complete instruction: accept, optional bus transaction, hand-off.
  // lat < 0 means the bus never answers.
  task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [7:0] wm,
                     input logic [31:0] rm, input logic sgn, input logic ren, input logic wen,
                     input logic [31:0] rdata, input logic rerr,
                     input int stall, input int lat, input int wbs);
    logic is_mem, mis, is_ld, e_err, chk_res;
    logic [31:0] e_res;
    logic [4:0]  rdv;
    logic [31:0] pcv;
    logic [1:0]  wdv;
    logic        rwe;
    int bud;
    rdv = 5'($urandom); pcv = $urandom; wdv = wd_tab[$urandom_range(0, 3)]; rwe = 1'($urandom);
    is_mem = ren | wen;
    is_ld  = ren & ~wen;
    mis    = is_mem && m_mis(a, wen, wm, rm);
    chk_res = 1'b1;
    bud = 0;
    while (!lsu_send_ready && bud < 20) begin
      @(posedge clk); #1; bud++;
    end
    chk("accept_ready", {31'b0, lsu_send_ready}, 32'd1);
    addr_input = a; wdata_input = wd; wmask_input = wm; rmask_input = rm;
    memory_read_signed_input = sgn; ren_input = ren; wen_input = wen;
    rd_input = rdv; pc_input = pcv; wdOp_input = wdv; reg_write_en_input = rwe;
    lsu_receive_valid = 1'b1;
    @(posedge clk); #1;
    lsu_receive_valid = 1'b0;
    addr_input = $urandom; wdata_input = $urandom; rd_input = 5'($urandom);
    chk("busy_not_ready", {31'b0, lsu_send_ready}, 32'd0);
    if (!is_mem || mis) begin
      chk("no_bus_req", {31'b0, mem_req_valid}, 32'd0);
      chk("fast_send", {31'b0, lsu_send_valid}, 32'd1);
      e_err = mis;
      e_res = '0;
    end else begin
      chk("req_valid", {31'b0, mem_req_valid}, 32'd1);
      chk("req_addr", mem_addr, {a[31:2], 2'b00});
      chk("req_wen", {31'b0, mem_wen}, {31'b0, wen});
      if (wen) begin
        chk("req_wdata", mem_wdata, m_wdata(a, wd));
        chk("req_wstrb", {28'b0, mem_wstrb}, {28'b0, m_wstrb(a, wm)});
      end
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        chk("req_hold", {31'b0, mem_req_valid}, 32'd1);
        chk("req_addr_hold", mem_addr, {a[31:2], 2'b00});
        if (wen) chk("req_wstrb_hold", {28'b0, mem_wstrb}, {28'b0, m_wstrb(a, wm)});
      end
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      chk("req_drop", {31'b0, mem_req_valid}, 32'd0);
      if (lat < 0) begin
        for (int i = 0; i < 3; i++) begin
          @(posedge clk); #1;
        end
        chk("timeout_early", {31'b0, lsu_send_valid}, 32'd0);
        @(posedge clk); #1;
        chk("timeout_send", {31'b0, lsu_send_valid}, 32'd1);
        e_err = 1'b1;
        e_res = '0;
      end else begin
        for (int i = 0; i < lat; i++) begin
          @(posedge clk); #1;
          chk("wait_no_send", {31'b0, lsu_send_valid}, 32'd0);
        end
        mem_resp_valid = 1'b1; mem_rdata = rdata; mem_resp_err = rerr;
        @(posedge clk); #1;
        mem_resp_valid = 1'b0; mem_resp_err = 1'b0; mem_rdata = $urandom;
        chk("resp_send", {31'b0, lsu_send_valid}, 32'd1);
        e_err = rerr;
        e_res = is_ld ? m_load(a, rdata, rm, sgn) : '0;
        if (is_ld && rerr) chk_res = 1'b0;
      end
    end
    chk("err", {31'b0, lsu_err}, {31'b0, e_err});
    if (chk_res) chk("mem_result", mem_result, e_res);
    chk("alu_result", alu_result, a);
    chk("rd", {27'b0, rd}, {27'b0, rdv});
    chk("pc", pc, pcv);
    chk("wdOp", {30'b0, wdOp}, {30'b0, wdv});
    chk("reg_write_en", {31'b0, reg_write_en}, {31'b0, rwe});
    for (int i = 0; i < wbs; i++) begin
      @(posedge clk); #1;
      chk("send_hold", {31'b0, lsu_send_valid}, 32'd1);
      if (chk_res) chk("result_hold", mem_result, e_res);
    end
    lsu_receive_ready = 1'b1;
    @(posedge clk); #1;
    lsu_receive_ready = 1'b0;
    chk("send_drop", {31'b0, lsu_send_valid}, 32'd0);
    chk("idle_ready", {31'b0, lsu_send_ready}, 32'd1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_send_ready"}, {31'b0, lsu_send_ready}, 32'd1);
    chk({tag, "_send_valid"}, {31'b0, lsu_send_valid}, 32'd0);
    chk({tag, "_req_valid"}, {31'b0, mem_req_valid}, 32'd0);
    chk({tag, "_mem_result"}, mem_result, 32'd0);
    chk({tag, "_alu_result"}, alu_result, 32'd0);
    chk({tag, "_err"}, {31'b0, lsu_err}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rdat;
    logic [7:0]  rwm;
    logic [31:0] rrm;
    int op, lat;
    wd_tab[0] = WD_ALU; wd_tab[1] = WD_MEM; wd_tab[2] = WD_PC4; wd_tab[3] = WD_IMM;
    rst = 1'b0;
    lsu_receive_valid = 0; addr_input = 0; wdata_input = 0; ren_input = 0; wen_input = 0;
    wmask_input = 0; rmask_input = 0; memory_read_signed_input = 0; reg_write_en_input = 0;
    rd_input = 0; pc_input = 0; wdOp_input = 0; mem_req_ready = 0; mem_resp_valid = 0;
    mem_rdata = 0; mem_resp_err = 0; lsu_receive_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    txn(32'h0000_1234, 32'h0, 8'h0, MASK_W, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 0, 0, 0);
    txn(32'h8000_0003, 32'h0, 8'h0, MASK_B, 1'b1, 1'b1, 1'b0, 32'h80FF_0000, 1'b0, 0, 1, 0);
    txn(32'h8000_0003, 32'h0, 8'h0, MASK_B, 1'b0, 1'b1, 1'b0, 32'h80FF_0000, 1'b0, 0, 1, 0);
    txn(32'h8000_0002, 32'h0000_BEEF, 8'h03, MASK_W, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 3, 0, 1);
    txn(32'h8000_0006, 32'h0, 8'h0, MASK_W, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 0, 0, 0);
    txn(32'h8000_0001, 32'h0, 8'h0, MASK_H, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 0, 0, 0);
    txn(32'h8000_0001, 32'h1234_5678, 8'h03, MASK_W, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 0, 0, 0);
    txn(32'h8000_0010, 32'h0, 8'h0, MASK_W, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1, -1, 0);
    txn(32'h8000_0010, 32'h0, 8'h0, MASK_W, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 0, 2, 0);
    txn(32'h8000_0020, 32'hCAFE_F00D, 8'h0F, MASK_W, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 0, 0, 0);
    txn(32'h8000_0002, 32'h0, 8'h0, MASK_H, 1'b1, 1'b1, 1'b0, 32'h8001_7FFF, 1'b0, 0, 0, 2);
    txn(32'h8000_0003, 32'h0000_00A5, 8'hF1, MASK_B, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 0, 0, 0);

    // Reset in the middle of WAIT abandons the access
    addr_input = 32'h8000_0040; ren_input = 1'b1; wen_input = 1'b0; rmask_input = MASK_W;
    lsu_receive_valid = 1'b1;
    @(posedge clk); #1;
    lsu_receive_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk_reset_state("midwait_rst");
    @(posedge clk); #1;
    rst = 1'b1;
    mem_resp_valid = 1'b1; mem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_reset_state("late_resp");
      @(posedge clk); #1;
    end

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      op = $urandom_range(0, 3);
      ra = $urandom;
      rdat = $urandom;
      case ($urandom_range(0, 2))
        0: rwm = 8'h01 | {4'($urandom), 4'h0};
        1: rwm = 8'h03 | {4'($urandom), 4'h0};
        default: rwm = 8'h0F | {4'($urandom), 4'h0};
      endcase
      case ($urandom_range(0, 2))
        0: rrm = MASK_B;
        1: rrm = MASK_H;
        default: rrm = MASK_W;
      endcase
      lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 2));
      txn(ra, $urandom, rwm, rrm, 1'($urandom), (op == 1) || (op == 3), (op >= 2),
          rdat, ($urandom_range(0, 7) == 0), $urandom_range(0, 3), lat, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
Load/store stage directly downstream of the execute stage; sits between EXU and the write-back stage.
- Accepts one instruction per handshake from EXU, carrying address, store data and memory controls.
- Performs at most one data-memory transaction over a simple request/response bus.
- Aligns and extends load data, then hands the result plus write-back controls to WBU.
- Non-memory instructions pass through without touching the bus.

Parameters:
XLEN, 32, datapath/address width (only 32 supported)
TIMEOUT, 255, max cycles in WAIT before a bus timeout error; 0 disables the timeout

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
lsu_receive_valid  in  1  EXU has a valid instruction
lsu_send_ready  out  1  LSU can accept (high only in IDLE)
addr_input  in  32  effective address (EXU alu_result)
wdata_input  in  32  store data, LSB-aligned (EXU src2)
ren_input  in  1  load
wen_input  in  1  store
wmask_input  in  8  store byte mask, LSB-aligned; bits [7:4] ignored
rmask_input  in  32  load mask: 0xFF / 0xFFFF / 0xFFFFFFFF
memory_read_signed_input  in  1  sign-extend load
reg_write_en_input  in  1  passthrough
rd_input  in  5  passthrough
pc_input  in  32  passthrough
wdOp_input  in  2  passthrough
mem_req_valid  out  1  bus request valid
mem_req_ready  in  1  bus accepts request
mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
mem_wen  out  1  request is a write
mem_wdata  out  32  lane-shifted store data
mem_wstrb  out  4  lane-shifted byte strobes
mem_resp_valid  in  1  response valid
mem_rdata  in  32  read word
mem_resp_err  in  1  bus error
lsu_send_valid  out  1  result valid to WBU
lsu_receive_ready  in  1  WBU accepts result
mem_result  out  32  aligned/extended load data (0 for non-loads)
alu_result  out  32  latched addr_input passthrough
reg_write_en, rd, pc, wdOp  out  1/5/32/2  latched passthroughs
lsu_err  out  1  misaligned access, bus error or timeout

Behaviour:
- Reset (rst=0, async):
  - State is IDLE.
  - All outputs 0 except lsu_send_ready=1.
  - The timeout counter is 0.
  - Reset during REQ or WAIT abandons the transaction. A late mem_resp_valid after reset is ignored in IDLE.
- FSM states: IDLE, REQ, WAIT, SEND.
- IDLE:
  - On lsu_receive_valid, latch all inputs.
  - No memory op (ren=wen=0): go to SEND next cycle, with mem_result=0 and lsu_err=0 (1-cycle latency).
  - Misaligned access: go to SEND with lsu_err=1, mem_result=0, and no bus request. Misaligned means rmask/wmask is halfword and addr[0]=1, or word and addr[1:0]≠0.
  - Otherwise: go to REQ.
  - If ren and wen are both 1, treat as a store.
- REQ:
  - mem_req_valid=1 with stable addr, wen, wdata and wstrb until mem_req_ready.
  - On mem_req_ready, go to WAIT and clear the counter.
  - mem_resp_valid in the same cycle as ready is not legal from the bus and is ignored.
- WAIT:
  - Counter increments every cycle.
  - On mem_resp_valid, latch the result, set lsu_err=mem_resp_err, and go to SEND.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT without a response, go to SEND with lsu_err=1 and mem_result=0.
- SEND:
  - lsu_send_valid=1 with stable outputs until lsu_receive_ready.
  - Then go to IDLE and drop valid in the same edge.
  - lsu_send_ready is 0 in every state except IDLE, so there is no back-to-back acceptance (throughput ≤ 1 per 2 cycles).
- Store lanes:
  - sh = addr[1:0]*8.
  - mem_wdata = wdata << sh.
  - mem_wstrb = wmask[3:0] << addr[1:0], truncated to 4 bits.
- Load:
  - raw = (mem_rdata >> sh) & rmask.
  - If memory_read_signed, sign-extend from bit 7 (rmask=0xFF) or bit 15 (0xFFFF).
  - Word loads pass raw through unchanged.
- Bus error on a store: lsu_err=1, mem_result=0.

Decomposition:
- Shared package holds:
  - FSM state enum.
  - Load mask constants (MASK_B=0xFF, MASK_H=0xFFFF, MASK_W=0xFFFFFFFF).
  - wdOp encodings shared with EXU and WBU.
- One sub-module, lsu_align: combinational store lane shifting, load extraction/extension and the misalign check. It is reused by future cache logic.

Test Plan:
- Non-memory op (addr=0x1234, ren=wen=0), WBU ready -> lsu_send_valid 1 cycle after accept, alu_result=0x1234, mem_result=0, no mem_req_valid.
- lb signed, addr=0x80000003, rdata=0x80FF_0000 -> mem_addr=0x80000000, mem_result=0xFFFFFF80; same with signed=0 -> 0x00000080.
- sh, addr=0x80000002, wdata=0x0000BEEF, wmask=0x03 -> mem_wdata=0xBEEF0000, mem_wstrb=0b1100, mem_wen=1; req held 3 cycles while mem_req_ready=0.
- lw at addr=0x80000006 -> no bus request, lsu_err=1 in SEND; lh at 0x80000001 likewise.
- TIMEOUT=4, load accepted, no response -> SEND with lsu_err=1 after 4 WAIT cycles; second run with mem_resp_err=1 -> lsu_err=1.
- Assert rst low mid-WAIT, then release and pulse mem_resp_valid -> outputs stay at reset values, lsu_send_ready=1, no spurious lsu_send_valid.
